// File: rtl/c3lib_gate_pkg.sv
// Shared state encoding for the c3lib gating-enable controller.
// The enum values are tied to the encoding constants so state_out always matches them.
package c3lib_gate_pkg;

    localparam logic [1:0] ST_ON_ENC    = 2'b00;
    localparam logic [1:0] ST_DRAIN_ENC = 2'b01;
    localparam logic [1:0] ST_OFF_ENC   = 2'b10;
    localparam logic [1:0] ST_WAKE_ENC  = 2'b11;

    typedef enum logic [1:0] {
        ON    = ST_ON_ENC,
        DRAIN = ST_DRAIN_ENC,
        OFF   = ST_OFF_ENC,
        WAKE  = ST_WAKE_ENC
    } gate_st_e;

endpackage

// File: rtl/c3lib_gate_en_ctrl.sv
// Gating-enable sequencer: drains until downstream is quiet, gates the AND cell off,
// and on release re-enables the path while holding the ack through a wake window.
module c3lib_gate_en_ctrl
    import c3lib_gate_pkg::*;
#(
    parameter int DRAIN_CYC = 4,
    parameter int WAKE_CYC  = 2,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate_req,
    input  logic       busy_in,
    output logic       en_out,
    output logic       gate_ack,
    output logic [1:0] state_out
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (DRAIN_CYC < 1 || DRAIN_CYC > CNT_MAX) begin : g_bad_drain
        $error("DRAIN_CYC out of range 1..2**CNT_W-1");
    end
    if (WAKE_CYC < 1 || WAKE_CYC > CNT_MAX) begin : g_bad_wake
        $error("WAKE_CYC out of range 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYC - 1);

    gate_st_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             ack_q, ack_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ON: begin
                if (gate_req) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // Release wins over busy and over a completed drain count.
                if (!gate_req) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else if (busy_in) begin
                    cnt_d = '0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OFF: begin
                if (!gate_req) begin
                    state_d = WAKE;
                    cnt_d   = '0;
                end
            end
            WAKE: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ON;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they change only on clk.
        en_d  = (state_d != OFF);
        ack_d = (state_d == OFF) || (state_d == WAKE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= ON;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
        end
    end

    assign en_out    = en_q;
    assign gate_ack  = ack_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_c3lib_gate_en_ctrl.sv
// Scoreboard bench for c3lib_gate_en_ctrl: a cycle model pushes expected outputs per edge,
// and fixed timing milestones from the protocol are checked against recorded traces.
module tb_c3lib_gate_en_ctrl;

    localparam int DRAIN_CYC = 4;
    localparam int WAKE_CYC  = 2;
    localparam int CNT_W     = 4;
    localparam int N_CYC     = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       gate_req;
    logic       busy_in;
    logic       en_out;
    logic       gate_ack;
    logic [1:0] state_out;

    c3lib_gate_en_ctrl #(
        .DRAIN_CYC(DRAIN_CYC),
        .WAKE_CYC (WAKE_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gate_req (gate_req),
        .busy_in  (busy_in),
        .en_out   (en_out),
        .gate_ack (gate_ack),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       ack;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state, written from the protocol description.
    int m_st  = 0;
    int m_cnt = 0;

    // Per-scenario traces indexed by cycle label (value visible after edge k is label k+1).
    logic       tr_en [0:N_CYC+1];
    logic       tr_ack[0:N_CYC+1];
    logic [1:0] tr_st [0:N_CYC+1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_step(input logic r, input logic req, input logic busy);
        exp_t e;
        if (r) begin
            m_st  = 0;
            m_cnt = 0;
        end else begin
            case (m_st)
                0: if (req) begin m_st = 1; m_cnt = 0; end
                1: begin
                    if (!req)                       begin m_st = 0; m_cnt = 0; end
                    else if (busy)                  m_cnt = 0;
                    else if (m_cnt == DRAIN_CYC-1)  begin m_st = 2; m_cnt = 0; end
                    else                            m_cnt++;
                end
                2: if (!req) begin m_st = 3; m_cnt = 0; end
                default: begin
                    if (m_cnt == WAKE_CYC-1) begin m_st = 0; m_cnt = 0; end
                    else                     m_cnt++;
                end
            endcase
        end
        e.st  = 2'(m_st);
        e.en  = (m_st != 2);
        e.ack = (m_st == 2) || (m_st == 3);
        return e;
    endfunction

    // One clock: drive inputs, push the model's prediction, then pop and compare on the falling edge.
    task automatic tick(input logic r, input logic req, input logic busy, input int lbl);
        exp_t e;
        rst      = r;
        gate_req = req;
        busy_in  = busy;
        exp_q.push_back(model_step(r, req, busy));
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("sb_en",  32'(en_out),    32'(e.en));
        check("sb_ack", 32'(gate_ack),  32'(e.ack));
        check("sb_st",  32'(state_out), 32'(e.st));
        if (lbl >= 0 && lbl <= N_CYC + 1) begin
            tr_en[lbl]  = en_out;
            tr_ack[lbl] = gate_ack;
            tr_st[lbl]  = state_out;
        end
    endtask

    // Scenario: gate_req high on edges [lo1,hi1] and [lo2,hi2], busy on edge bz, rst on edge rs.
    task automatic run_scn(input int lo1, input int hi1, input int lo2, input int hi2,
                           input int bz, input int rs);
        tick(1'b1, 1'b0, 1'b0, -1);
        tick(1'b1, 1'b0, 1'b0, -1);
        for (int k = 0; k < N_CYC; k++) begin
            tick(k == rs,
                 (k >= lo1 && k <= hi1) || (k >= lo2 && k <= hi2),
                 k == bz,
                 k + 1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        gate_req = 1'b0;
        busy_in  = 1'b0;
        @(negedge clk);

        // Reset then clean gate / wake.
        run_scn(10, 19, -1, -1, -1, -1);
        check("rst_en",    32'(tr_en[1]),  32'd1);
        check("rst_ack",   32'(tr_ack[1]), 32'd0);
        check("rst_st",    32'(tr_st[1]),  32'd0);
        check("drain_in",  32'(tr_st[11]), 32'd1);
        check("gate_pre",  32'(tr_en[14]), 32'd1);
        check("gate_en",   32'(tr_en[15]), 32'd0);
        check("gate_ack",  32'(tr_ack[15]), 32'd1);
        check("wake_pre",  32'(tr_en[20]), 32'd0);
        check("wake_en",   32'(tr_en[21]), 32'd1);
        check("wake_ack1", 32'(tr_ack[22]), 32'd1);
        check("wake_ack0", 32'(tr_ack[23]), 32'd0);

        // Busy on the third DRAIN cycle delays gate-off to cycle 18.
        run_scn(10, 25, -1, -1, 13, -1);
        check("busy_17", 32'(tr_en[17]), 32'd1);
        check("busy_18", 32'(tr_en[18]), 32'd0);
        check("busy_st", 32'(tr_st[18]), 32'd2);

        // Drain abort: short request never gates.
        run_scn(10, 12, -1, -1, -1, -1);
        check("abort_st1", 32'(tr_st[11]), 32'd1);
        check("abort_st0", 32'(tr_st[14]), 32'd0);
        for (int k = 1; k <= N_CYC; k++) begin
            check("abort_en",  32'(tr_en[k]),  32'd1);
            check("abort_ack", 32'(tr_ack[k]), 32'd0);
        end

        // Re-request during WAKE: WAKE completes first.
        run_scn(10, 19, 21, 39, -1, -1);
        check("rereq_wake", 32'(tr_st[22]), 32'd3);
        check("rereq_on",   32'(tr_st[23]), 32'd0);
        check("rereq_drn",  32'(tr_st[24]), 32'd1);
        check("rereq_drn2", 32'(tr_st[27]), 32'd1);
        check("rereq_off",  32'(tr_st[28]), 32'd2);

        // Reset while OFF, request still held: restart from ON with a cleared counter.
        run_scn(10, 39, -1, -1, -1, 17);
        check("mid_off",  32'(tr_st[17]), 32'd2);
        check("mid_en",   32'(tr_en[18]), 32'd1);
        check("mid_ack",  32'(tr_ack[18]), 32'd0);
        check("mid_st",   32'(tr_st[18]), 32'd0);
        check("mid_drn",  32'(tr_st[22]), 32'd1);
        check("mid_reoff", 32'(tr_st[23]), 32'd2);

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
